// File: rtl/op_decode_stage.sv
// op_decode_stage: registered opcode decoder between fetch and register-read.
// Accepts {instruction, PC} beats over valid/ready, decodes the opcode into an
// 11-bit one-hot class vector, flags illegal encodings, absorbs downstream
// stalls in a two-entry (output + skid) buffer, supports flush and keeps a
// saturating count of illegal beats delivered downstream.
module op_decode_stage #(
    parameter int unsigned ILEN          = 32,
    parameter int unsigned PC_W          = 32,
    parameter int unsigned ENABLE_SYSTEM = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iValid,
    output logic             oReady,
    input  logic [ILEN-1:0]  iInstr,
    input  logic [PC_W-1:0]  iPC,
    input  logic             iFlush,
    output logic             oValid,
    input  logic             iReady,
    output logic [ILEN-1:0]  oInstr,
    output logic [PC_W-1:0]  oPC,
    output logic [10:0]      oType,
    output logic             oIllegal,
    output logic [CNT_W-1:0] oIllegalCount
);

    localparam int unsigned TYPE_W = 11;
    localparam int unsigned OPC_W  = 7;

    // Opcode values of the decoded classes
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'd35;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'd3;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'd19;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'd55;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'd23;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'd51;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'd103;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'd111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'd99;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'd15;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'd115;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              ready_q;
    logic              valid_q;

    logic [OPC_W-1:0]  opcode;
    logic [TYPE_W-1:0] dec_type;
    logic              dec_illegal;

    logic [ILEN-1:0]   out_instr_q;
    logic [PC_W-1:0]   out_pc_q;
    logic [TYPE_W-1:0] out_type_q;
    logic              out_illegal_q;

    logic [ILEN-1:0]   skid_instr_q;
    logic [PC_W-1:0]   skid_pc_q;
    logic [TYPE_W-1:0] skid_type_q;
    logic              skid_illegal_q;

    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              deliver;
    logic              out_load_in;
    logic              out_load_skid;
    logic              skid_load;
    logic              cnt_inc;

    assign opcode  = iInstr[OPC_W-1:0];
    assign accept  = iValid & ready_q;
    assign deliver = valid_q & iReady;

    // Opcode decode of the incoming beat into one-hot class plus illegal flag
    always_comb begin
        dec_type    = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_STORE:  dec_type[0] = 1'b1;
            OPC_LOAD:   dec_type[1] = 1'b1;
            OPC_OPIMM:  dec_type[2] = 1'b1;
            OPC_LUI:    dec_type[3] = 1'b1;
            OPC_AUIPC:  dec_type[4] = 1'b1;
            OPC_OP:     dec_type[5] = 1'b1;
            OPC_JALR:   dec_type[6] = 1'b1;
            OPC_JAL:    dec_type[7] = 1'b1;
            OPC_BRANCH: dec_type[8] = 1'b1;
            OPC_FENCE: begin
                if (ENABLE_SYSTEM != 0) dec_type[9] = 1'b1;
                else                    dec_illegal = 1'b1;
            end
            OPC_SYSTEM: begin
                if (ENABLE_SYSTEM != 0) dec_type[10] = 1'b1;
                else                    dec_illegal  = 1'b1;
            end
            default:    dec_illegal = 1'b1;
        endcase
        // Compressed-looking encodings are never legal here
        if (iInstr[1:0] != 2'b11) begin
            dec_type    = '0;
            dec_illegal = 1'b1;
        end
    end

    // State register plus registered handshake flags derived from next state
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
            valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Next-state logic; flush overrides any handshake in the same cycle
    always_comb begin
        state_d = state_q;
        if (iFlush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !deliver)      state_d = ST_TWO;
                    else if (!accept && deliver) state_d = ST_EMPTY;
                end
                ST_TWO:   if (deliver) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Datapath load controls for the output and skid entries
    always_comb begin
        out_load_in   = 1'b0;
        out_load_skid = 1'b0;
        skid_load     = 1'b0;
        if (!iFlush) begin
            case (state_q)
                ST_EMPTY: out_load_in = accept;
                ST_ONE: begin
                    out_load_in = accept & deliver;
                    skid_load   = accept & ~deliver;
                end
                ST_TWO:   out_load_skid = deliver;
                default:  ;
            endcase
        end
    end

    // Output entry: loads from the decoder, or from the skid entry when draining
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            out_type_q    <= '0;
            out_illegal_q <= 1'b0;
        end else if (out_load_in) begin
            out_instr_q   <= iInstr;
            out_pc_q      <= iPC;
            out_type_q    <= dec_type;
            out_illegal_q <= dec_illegal;
        end else if (out_load_skid) begin
            out_instr_q   <= skid_instr_q;
            out_pc_q      <= skid_pc_q;
            out_type_q    <= skid_type_q;
            out_illegal_q <= skid_illegal_q;
        end
    end

    // Skid entry: captures the beat accepted while the output is stalled
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            skid_instr_q   <= '0;
            skid_pc_q      <= '0;
            skid_type_q    <= '0;
            skid_illegal_q <= 1'b0;
        end else if (skid_load) begin
            skid_instr_q   <= iInstr;
            skid_pc_q      <= iPC;
            skid_type_q    <= dec_type;
            skid_illegal_q <= dec_illegal;
        end
    end

    // Saturating count of illegal beats actually handed downstream
    assign cnt_inc = deliver & out_illegal_q & ~iFlush & (cnt_q != {CNT_W{1'b1}});

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign oReady        = ready_q;
    assign oValid        = valid_q;
    assign oInstr        = out_instr_q;
    assign oPC           = out_pc_q;
    assign oType         = out_type_q;
    assign oIllegal      = out_illegal_q;
    assign oIllegalCount = cnt_q;

endmodule

// File: doc/op_decode_stage.md
Name: op_decode_stage

Overview:
Parametrised, registered successor to the combinational opcode decoder. It sits between fetch and the register-read/control stage. It accepts {instruction, PC} beats over a valid/ready handshake and decodes the opcode into an 11-bit one-hot class vector. Additional capabilities:
- flags illegal encodings
- absorbs downstream stalls in a 2-entry skid buffer
- supports pipeline flush
- keeps a saturating illegal-instruction counter

Parameters:
ILEN, 32, instruction width (bits [6:0] are the opcode; must be ≥ 7)
PC_W, 32, PC sideband width carried alongside the instruction
ENABLE_SYSTEM, 1, when 1 FENCE/SYSTEM opcodes decode legally; when 0 they are flagged illegal
CNT_W, 16, width of the illegal-instruction counter

Ports:
iClk  in  1  clock, all state updates on rising edge
iRstN  in  1  asynchronous active-low reset
iValid  in  1  upstream beat valid
oReady  out  1  stage can accept a beat this cycle
iInstr  in  ILEN  instruction word
iPC  in  PC_W  instruction PC
iFlush  in  1  synchronous flush (branch mispredict / trap)
oValid  out  1  decoded beat valid
iReady  in  1  downstream accepts beat
oInstr  out  ILEN  registered instruction
oPC  out  PC_W  registered PC
oType  out  11  one-hot class: [0]store 35, [1]load 3, [2]op-imm 19, [3]lui 55, [4]auipc 23, [5]op 51, [6]jalr 103, [7]jal 111, [8]branch 99, [9]fence 15, [10]system 115
oIllegal  out  1  current output beat is illegal
oIllegalCount  out  CNT_W  saturating count of illegal beats delivered

Behaviour:
- Reset (iRstN low, asynchronous): all outputs 0, both entries empty, counter 0. oReady = 1 from the first cycle after release.
- Decode (combinational on input, result registered):
  - opcode = iInstr[6:0]; exactly one oType bit is set for a legal listed opcode.
  - Illegal when iInstr[1:0] != 2'b11, the opcode is unlisted, or the opcode is 15/115 with ENABLE_SYSTEM = 0.
  - For illegal beats: oType = 0 and oIllegal = 1.
- Storage: output register (OUT) plus skid register (SKID). States:
  - EMPTY: nothing held.
  - ONE: OUT valid, SKID empty.
  - TWO: both full.
- Handshakes: accept = iValid & oReady; deliver = oValid & iReady. oReady = (state != TWO), registered. oValid = (state != EMPTY).
- Transitions:
  - EMPTY: accept → ONE (OUT loaded).
  - ONE:
    - accept & deliver → ONE (OUT replaced).
    - accept & !deliver → TWO (SKID loaded).
    - deliver & !accept → EMPTY.
  - TWO: deliver → ONE (OUT ← SKID). Accept is impossible in TWO because oReady = 0.
- Latency: 1 cycle from accept to oValid when the stage is empty. Beat order is strictly preserved.
- Output stability: while oValid & !iReady, oInstr/oPC/oType/oIllegal are held stable.
- Flush (iFlush high at an edge):
  - state → EMPTY, any same-cycle input beat is dropped, and oValid = 0 next cycle.
  - The counter is not cleared.
  - Flush has priority over accept and deliver.
- Counter: increments by 1 on each deliver with oIllegal = 1, and saturates at 2^CNT_W − 1.
- Reset asserted mid-operation: asynchronous clear of everything, regardless of handshake.

Test Plan:
- Reset, then accept iInstr=0x00000013 with iReady=1 → next cycle oValid=1, oType=11'h004, oIllegal=0, oPC echoes iPC.
- Back-to-back 0x0000006F, 0x00008067, 0x00000063 with iReady=1 → oType sequence 11'h080, 11'h040, 11'h100, one per cycle.
- Hold iReady=0, send 3 beats → first two captured; oReady=0 after the second; third held upstream. Raise iReady → beats emerge in order and oReady returns to 1.
- Send 0xFFFFFFFF, 0x00000000, and 0x00000073 with ENABLE_SYSTEM=0 → each gives oIllegal=1, oType=0, and oIllegalCount reaches 3. With ENABLE_SYSTEM=1, 0x00000073 gives oType=11'h400.
- State TWO, assert iFlush with iValid=1 → next cycle oValid=0, oReady=1, input beat discarded, counter unchanged.
- CNT_W=2: deliver 5 illegal beats → count 1, 2, 3, 3, 3. Assert iRstN low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
